// File: rtl/memory_arbiter_rr_pkg.sv
// rtl/memory_arbiter_rr_pkg.sv - shared types and constants for the multicore RAM arbiter
// RAM handshake types, arbiter FSM encoding and pointer-width helper.
package memory_arbiter_rr_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  // Plain-vector FSM encoding keeps the state register readable by legacy tooling.
  typedef logic [0:0] arb_state_t;
  localparam arb_state_t IDLE  = 1'b0;
  localparam arb_state_t GRANT = 1'b1;

  localparam int MEMARB_MAX_CPUS = 8;

  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/memory_arbiter_rr_if.sv
// rtl/memory_arbiter_rr_if.sv - cache-side and RAM-side bus bundle of the arbiter
// slave: arbiter view; master: caches plus RAM model view.
interface memory_arbiter_rr_if
  import memory_arbiter_rr_pkg::*;
#(
  parameter int CPUS = 2
);

  logic [CPUS-1:0]  iREN;
  word_t [CPUS-1:0] iaddr;
  logic [CPUS-1:0]  iwait;
  word_t [CPUS-1:0] iload;

  logic [CPUS-1:0]  dREN;
  logic [CPUS-1:0]  dWEN;
  word_t [CPUS-1:0] daddr;
  word_t [CPUS-1:0] dstore;
  logic [CPUS-1:0]  dwait;
  word_t [CPUS-1:0] dload;

  logic             ramREN;
  logic             ramWEN;
  word_t            ramaddr;
  word_t            ramstore;
  word_t            ramload;
  ramstate_t        ramstate;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );

endinterface

// File: rtl/memory_arbiter_rr_rr_picker.sv
// rtl/memory_arbiter_rr_rr_picker.sv - combinational round-robin winner select
// Returns the first requester at or after rr_ptr, wrapping modulo CPUS.
module rr_picker #(
  parameter int CPUS  = 2,
  parameter int PTR_W = 1
) (
  input  logic [CPUS-1:0]  req,
  input  logic [PTR_W-1:0] rr_ptr,
  output logic             valid,
  output logic [PTR_W-1:0] winner
);

  localparam logic [PTR_W:0] CPUS_W = (PTR_W+1)'(CPUS);

  logic [PTR_W:0] idx;

  // Scan from farthest to nearest so the nearest requester is written last.
  always_comb begin
    valid  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int i = CPUS - 1; i >= 0; i--) begin
      idx = {1'b0, rr_ptr} + (PTR_W+1)'(i);
      if (idx >= CPUS_W) idx = idx - CPUS_W;
      if (req[idx[PTR_W-1:0]]) begin
        valid  = 1'b1;
        winner = idx[PTR_W-1:0];
      end
    end
  end

endmodule

// File: rtl/memory_arbiter_rr.sv
// rtl/memory_arbiter_rr.sv - round-robin I/D arbiter of CPUS cores onto one RAM port
// Optional MEMARB_PERF_EN adds saturating per-core grant_cnt/stall_cnt outputs.
module memory_arbiter_rr
  import memory_arbiter_rr_pkg::*;
#(
  parameter int CPUS = 2
) (
  input  logic              CLK,
  input  logic              RST,
`ifdef MEMARB_PERF_EN
  output word_t [CPUS-1:0]  grant_cnt,
  output word_t [CPUS-1:0]  stall_cnt,
`endif
  memory_arbiter_rr_if.slave bus
);

  localparam int PTR_W = ptr_width(CPUS);

  arb_state_t       state;
  logic [PTR_W-1:0] owner;
  logic             owner_is_d;
  logic [PTR_W-1:0] rr_ptr;

  logic             pick_valid;
  logic [PTR_W-1:0] pick_winner;
  logic [PTR_W-1:0] next_ptr;
  logic [CPUS-1:0]  dreq;
  logic [CPUS-1:0]  req;
  logic [CPUS-1:0]  owner_hot;
  logic             active;
  logic             done;
  logic             ram_ren;
  logic             ram_wen;
  word_t            ram_addr;
  word_t            ram_store;

  assign dreq = bus.dREN | bus.dWEN;
  assign req  = bus.iREN | dreq;

  rr_picker #(
    .CPUS  (CPUS),
    .PTR_W (PTR_W)
  ) u_picker (
    .req    (req),
    .rr_ptr (rr_ptr),
    .valid  (pick_valid),
    .winner (pick_winner)
  );

  // RAM port follows the live request of the registered owner channel only.
  always_comb begin
    active    = 1'b0;
    ram_ren   = 1'b0;
    ram_wen   = 1'b0;
    ram_addr  = '0;
    ram_store = '0;
    if (state == GRANT) begin
      if (owner_is_d) begin
        active    = dreq[owner];
        ram_wen   = bus.dWEN[owner];
        ram_ren   = bus.dREN[owner] & ~bus.dWEN[owner];
        ram_addr  = bus.daddr[owner];
        ram_store = bus.dstore[owner];
      end else begin
        active    = bus.iREN[owner];
        ram_ren   = bus.iREN[owner];
        ram_addr  = bus.iaddr[owner];
      end
    end
  end

  // ERROR and BUSY both simply hold the grant until ACCESS.
  assign done      = active & (bus.ramstate == ACCESS);
  assign owner_hot = CPUS'(1) << owner;
  assign next_ptr  = (owner == PTR_W'(CPUS - 1)) ? '0 : owner + 1'b1;

  assign bus.iwait    = ~(owner_hot & {CPUS{done & ~owner_is_d}});
  assign bus.dwait    = ~(owner_hot & {CPUS{done &  owner_is_d}});
  assign bus.iload    = {CPUS{bus.ramload}};
  assign bus.dload    = {CPUS{bus.ramload}};
  assign bus.ramREN   = ram_ren;
  assign bus.ramWEN   = ram_wen;
  assign bus.ramaddr  = ram_addr;
  assign bus.ramstore = ram_store;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      owner      <= '0;
      owner_is_d <= 1'b0;
      rr_ptr     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            owner      <= pick_winner;
            owner_is_d <= dreq[pick_winner];
            state      <= GRANT;
          end
        end
        default: begin
          // A withdrawn request releases the port and still rotates priority.
          if (done || !active) begin
            state  <= IDLE;
            rr_ptr <= next_ptr;
          end
        end
      endcase
    end
  end

`ifdef MEMARB_PERF_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      grant_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      for (int k = 0; k < CPUS; k++) begin
        if (done && (owner == PTR_W'(k)) && (grant_cnt[k] != '1))
          grant_cnt[k] <= grant_cnt[k] + 32'd1;
        if (req[k] && !((state == GRANT) && (owner == PTR_W'(k))) && (stall_cnt[k] != '1))
          stall_cnt[k] <= stall_cnt[k] + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_memory_arbiter_rr.sv
// tb/tb_memory_arbiter_rr.sv - scoreboard bench for memory_arbiter_rr
module tb_memory_arbiter_rr;
  import memory_arbiter_rr_pkg::*;

  localparam int CPUS = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  memory_arbiter_rr_if #(.CPUS(CPUS)) bus ();
`ifdef MEMARB_PERF_EN
  word_t [CPUS-1:0] grant_cnt;
  word_t [CPUS-1:0] stall_cnt;
`endif

  memory_arbiter_rr #(.CPUS(CPUS)) dut (
    .CLK       (clk),
    .RST       (rst),
`ifdef MEMARB_PERF_EN
    .grant_cnt (grant_cnt),
    .stall_cnt (stall_cnt),
`endif
    .bus       (bus)
  );

  typedef struct {
    int    core;
    bit    is_d;
    bit    ren;
    bit    wen;
    word_t addr;
    word_t store;
  } txn_t;

  typedef struct {
    bit   timeout;
    int   cycles;
    txn_t t;
    bit   hold_ok;
    bit   one_pulse;
    bit   load_ok;
    bit   released;
  } obs_t;

  txn_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic txn_t mk(input int core, input bit is_d, input bit ren, input bit wen,
                              input word_t addr, input word_t store);
    txn_t t;
    t.core = core; t.is_d = is_d; t.ren = ren; t.wen = wen; t.addr = addr; t.store = store;
    return t;
  endfunction

  function automatic string fmt(input txn_t t);
    return $sformatf("core=%0d d=%0b ren=%0b wen=%0b addr=%h store=%h",
                     t.core, t.is_d, t.ren, t.wen, t.addr, t.store);
  endfunction

  // RAM model: waits for an enable, holds `hold` for lat-1 cycles, then ACCESS for one cycle.
  task automatic ram_serve(input int lat, input ramstate_t hold, input bit retire, output obs_t o);
    bit    seen;
    int    zeros;
    word_t v;
    seen = 1'b0;
    o.timeout = 1'b0; o.cycles = 0; o.hold_ok = 1'b1; o.one_pulse = 1'b0;
    o.load_ok = 1'b1; o.released = 1'b0;
    o.t = mk(-1, 1'b0, 1'b0, 1'b0, '0, '0);
    while (!seen && o.cycles < 64) begin
      @(negedge clk); #1;
      o.cycles++;
      seen = bus.ramREN | bus.ramWEN;
    end
    if (!seen) begin
      o.timeout = 1'b1;
      return;
    end
    o.t.ren = bus.ramREN; o.t.wen = bus.ramWEN; o.t.addr = bus.ramaddr; o.t.store = bus.ramstore;
    for (int i = 1; i < lat; i++) begin
      bus.ramstate = hold;
      @(negedge clk); #1;
      if (!(&bus.iwait) || !(&bus.dwait) || !(bus.ramREN | bus.ramWEN)) o.hold_ok = 1'b0;
    end
    v = $urandom;
    bus.ramload  = v;
    bus.ramstate = ACCESS;
    #1;
    zeros = 0;
    for (int k = 0; k < CPUS; k++) begin
      if (!bus.iwait[k]) begin zeros++; o.t.core = k; o.t.is_d = 1'b0; end
      if (!bus.dwait[k]) begin zeros++; o.t.core = k; o.t.is_d = 1'b1; end
      if (bus.iload[k] !== v || bus.dload[k] !== v) o.load_ok = 1'b0;
    end
    o.one_pulse = (zeros == 1);
    @(negedge clk);
    bus.ramstate = FREE;
    #1;
    o.released = (&bus.iwait) && (&bus.dwait);
    if (retire && o.t.core >= 0) begin
      if (o.t.is_d) begin
        bus.dREN[o.t.core] = 1'b0;
        bus.dWEN[o.t.core] = 1'b0;
      end else begin
        bus.iREN[o.t.core] = 1'b0;
      end
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk); #1;
    rst = 1'b1;
    @(negedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    obs_t o;
    txn_t e;
    for (int k = 0; k < CPUS; k++) begin
      bus.iREN[k] = 1'b1; bus.dREN[k] = 1'b1;
      bus.iaddr[k] = 32'h80 + 32'(k * 4); bus.daddr[k] = 32'h40 + 32'(k * 4);
    end
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (bus.ramREN !== 1'b0 || bus.ramWEN !== 1'b0) begin
      errors++; $display("FAIL reset_enables ren=%b wen=%b expected 0 0", bus.ramREN, bus.ramWEN);
    end
    checks++;
    if (bus.iwait !== 4'hF || bus.dwait !== 4'hF) begin
      errors++; $display("FAIL reset_waits iwait=%b dwait=%b expected 1111 1111", bus.iwait, bus.dwait);
    end
    checks++;
    if (bus.ramaddr !== 32'h0 || bus.ramstore !== 32'h0) begin
      errors++; $display("FAIL reset_bus addr=%h store=%h expected 0 0", bus.ramaddr, bus.ramstore);
    end
    rst = 1'b0;
    exp_q.push_back(mk(0, 1'b1, 1'b1, 1'b0, 32'h40, 32'h0));
    ram_serve(1, BUSY, 1'b1, o);
    bus.iREN = '0; bus.dREN = '0;
    checks++;
    if (o.timeout || exp_q.size() == 0) begin
      errors++; $display("FAIL reset_first_grant no grant seen, timeout=%0b", o.timeout);
    end else begin
      e = exp_q.pop_front();
      if (o.t !== e) begin
        errors++; $display("FAIL reset_first_grant got %s expected %s", fmt(o.t), fmt(e));
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_ifetch();
    obs_t o;
    txn_t e;
    #1;
    bus.iREN[0] = 1'b1; bus.iaddr[0] = 32'h100;
    exp_q.push_back(mk(0, 1'b0, 1'b1, 1'b0, 32'h100, 32'h0));
    ram_serve(3, BUSY, 1'b1, o);
    checks++;
    if (o.timeout || exp_q.size() == 0) begin
      errors++; $display("FAIL ifetch no grant seen, timeout=%0b", o.timeout);
    end else begin
      e = exp_q.pop_front();
      if (o.t.core !== e.core || o.t.is_d !== e.is_d || o.t.ren !== e.ren ||
          o.t.wen !== e.wen || o.t.addr !== e.addr) begin
        errors++; $display("FAIL ifetch got %s expected %s", fmt(o.t), fmt(e));
      end
    end
    checks++;
    if (o.cycles !== 1) begin
      errors++; $display("FAIL ifetch_latency grant after %0d cycles, expected 1", o.cycles);
    end
    checks++;
    if (!(o.hold_ok && o.one_pulse && o.load_ok && o.released)) begin
      errors++; $display("FAIL ifetch_handshake hold=%0b pulse=%0b load=%0b released=%0b expected 1 1 1 1",
                         o.hold_ok, o.one_pulse, o.load_ok, o.released);
    end
  endtask

  task automatic test_d_over_i();
    obs_t o;
    txn_t e;
    bus.dWEN[0] = 1'b1; bus.daddr[0] = 32'h200; bus.dstore[0] = 32'hDEADBEEF;
    bus.iREN[0] = 1'b1; bus.iaddr[0] = 32'h104;
    exp_q.push_back(mk(0, 1'b1, 1'b0, 1'b1, 32'h200, 32'hDEADBEEF));
    exp_q.push_back(mk(0, 1'b0, 1'b1, 1'b0, 32'h104, 32'h0));
    for (int n = 0; n < 3; n++) begin
      if (n == 2) begin
        bus.dREN[2] = 1'b1; bus.dWEN[2] = 1'b1; bus.daddr[2] = 32'h220; bus.dstore[2] = 32'h12345678;
        exp_q.push_back(mk(2, 1'b1, 1'b0, 1'b1, 32'h220, 32'h12345678));
      end
      ram_serve(3, ERROR, 1'b1, o);
      checks++;
      if (o.timeout || exp_q.size() == 0) begin
        errors++; $display("FAIL d_over_i[%0d] no grant seen, timeout=%0b", n, o.timeout);
      end else begin
        e = exp_q.pop_front();
        if (o.t !== e) begin
          errors++; $display("FAIL d_over_i[%0d] got %s expected %s", n, fmt(o.t), fmt(e));
        end
      end
      checks++;
      if (!(o.hold_ok && o.one_pulse && o.load_ok && o.released)) begin
        errors++; $display("FAIL d_over_i_handshake[%0d] hold=%0b pulse=%0b load=%0b released=%0b expected 1 1 1 1",
                           n, o.hold_ok, o.one_pulse, o.load_ok, o.released);
      end
    end
  endtask

  task automatic test_rotation();
    obs_t o;
    txn_t e;
    pulse_reset();
    for (int k = 0; k < CPUS; k++) begin
      bus.dREN[k] = 1'b1; bus.daddr[k] = 32'h1000 + 32'(k * 4);
    end
    for (int n = 0; n < 5; n++) exp_q.push_back(mk(n % CPUS, 1'b1, 1'b1, 1'b0, 32'h1000 + 32'((n % CPUS) * 4), 32'h0));
    for (int n = 0; n < 5; n++) begin
      ram_serve(1 + (n % 3), BUSY, 1'b0, o);
      checks++;
      if (o.timeout || exp_q.size() == 0) begin
        errors++; $display("FAIL rotation[%0d] no grant seen, timeout=%0b", n, o.timeout);
      end else begin
        e = exp_q.pop_front();
        if (o.t.core !== e.core || o.t.is_d !== e.is_d || o.t.ren !== e.ren ||
            o.t.wen !== e.wen || o.t.addr !== e.addr) begin
          errors++; $display("FAIL rotation[%0d] got %s expected %s", n, fmt(o.t), fmt(e));
        end
      end
      checks++;
      if (!(o.hold_ok && o.one_pulse && o.load_ok && o.released)) begin
        errors++; $display("FAIL rotation_handshake[%0d] hold=%0b pulse=%0b load=%0b released=%0b expected 1 1 1 1",
                           n, o.hold_ok, o.one_pulse, o.load_ok, o.released);
      end
    end
    bus.dREN = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_withdraw();
    obs_t o;
    txn_t e;
    bit   seen;
    #1;
    bus.dREN[1] = 1'b1; bus.daddr[1] = 32'h300;
    seen = 1'b0;
    for (int n = 0; n < 16 && !seen; n++) begin
      @(negedge clk); #1;
      seen = bus.ramREN;
    end
    checks++;
    if (!seen || bus.ramaddr !== 32'h300) begin
      errors++; $display("FAIL withdraw_grant seen=%0b addr=%h expected 1 00000300", seen, bus.ramaddr);
    end
    bus.dREN[1] = 1'b0;
    #1;
    checks++;
    if (bus.ramREN !== 1'b0 || bus.ramWEN !== 1'b0 || bus.dwait[1] !== 1'b1) begin
      errors++; $display("FAIL withdraw_drop ren=%b wen=%b dwait1=%b expected 0 0 1", bus.ramREN, bus.ramWEN, bus.dwait[1]);
    end
    @(negedge clk); #1;
    checks++;
    if (bus.ramREN !== 1'b0 || bus.iwait !== 4'hF || bus.dwait !== 4'hF) begin
      errors++; $display("FAIL withdraw_idle ren=%b iwait=%b dwait=%b expected 0 1111 1111", bus.ramREN, bus.iwait, bus.dwait);
    end
    // pointer moved past core1, so core2 is served ahead of core1
    bus.dREN[1] = 1'b1; bus.dREN[2] = 1'b1; bus.daddr[2] = 32'h304;
    exp_q.push_back(mk(2, 1'b1, 1'b1, 1'b0, 32'h304, 32'h0));
    exp_q.push_back(mk(1, 1'b1, 1'b1, 1'b0, 32'h300, 32'h0));
    for (int n = 0; n < 2; n++) begin
      ram_serve(2, BUSY, 1'b1, o);
      checks++;
      if (o.timeout || exp_q.size() == 0) begin
        errors++; $display("FAIL withdraw_after[%0d] no grant seen, timeout=%0b", n, o.timeout);
      end else begin
        e = exp_q.pop_front();
        if (o.t.core !== e.core || o.t.is_d !== e.is_d || o.t.addr !== e.addr || o.t.ren !== e.ren) begin
          errors++; $display("FAIL withdraw_after[%0d] got %s expected %s", n, fmt(o.t), fmt(e));
        end
      end
    end
  endtask

  task automatic test_reset_mid_grant();
    obs_t o;
    txn_t e;
    bit   seen;
    bus.dWEN[3] = 1'b1; bus.daddr[3] = 32'h3F0; bus.dstore[3] = 32'hA5A5A5A5;
    seen = 1'b0;
    for (int n = 0; n < 16 && !seen; n++) begin
      @(negedge clk); #1;
      seen = bus.ramWEN;
    end
    checks++;
    if (!seen || bus.ramstore !== 32'hA5A5A5A5) begin
      errors++; $display("FAIL rst_mid_grant_setup seen=%0b store=%h expected 1 a5a5a5a5", seen, bus.ramstore);
    end
    rst = 1'b1; bus.ramstate = BUSY;
    @(negedge clk); #1;
    bus.ramstate = ACCESS;
    #1;
    checks++;
    if (bus.ramREN !== 1'b0 || bus.ramWEN !== 1'b0 || bus.iwait !== 4'hF || bus.dwait !== 4'hF) begin
      errors++; $display("FAIL rst_mid_grant ren=%b wen=%b iwait=%b dwait=%b expected 0 0 1111 1111",
                         bus.ramREN, bus.ramWEN, bus.iwait, bus.dwait);
    end
    bus.ramstate = FREE; bus.dWEN[3] = 1'b0;
    @(negedge clk); #1;
    rst = 1'b0;
    bus.dREN[3] = 1'b1; bus.dREN[0] = 1'b1; bus.daddr[0] = 32'h3E0;
    exp_q.push_back(mk(0, 1'b1, 1'b1, 1'b0, 32'h3E0, 32'h0));
    exp_q.push_back(mk(3, 1'b1, 1'b1, 1'b0, 32'h3F0, 32'h0));
    for (int n = 0; n < 2; n++) begin
      ram_serve(1, BUSY, 1'b1, o);
      checks++;
      if (o.timeout || exp_q.size() == 0) begin
        errors++; $display("FAIL rst_after[%0d] no grant seen, timeout=%0b", n, o.timeout);
      end else begin
        e = exp_q.pop_front();
        if (o.t.core !== e.core || o.t.is_d !== e.is_d || o.t.addr !== e.addr || o.t.ren !== e.ren) begin
          errors++; $display("FAIL rst_after[%0d] got %s expected %s", n, fmt(o.t), fmt(e));
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_empty left=%0d expected 0", exp_q.size());
    end
  endtask

`ifdef MEMARB_PERF_EN
  task automatic test_perf();
    obs_t o;
    pulse_reset();
    for (int n = 0; n < 5; n++) begin
      bus.iREN[0] = 1'b1; bus.iaddr[0] = 32'h500 + 32'(n * 4);
      ram_serve(1, BUSY, 1'b1, o);
    end
    checks++;
    if (grant_cnt[0] !== 32'd5) begin
      errors++; $display("FAIL perf_grant_cnt0 got %0d expected 5", grant_cnt[0]);
    end
    pulse_reset();
    bus.dREN[0] = 1'b1; bus.dREN[1] = 1'b1;
    ram_serve(5, BUSY, 1'b1, o);
    ram_serve(1, BUSY, 1'b1, o);
    checks++;
    if (stall_cnt[1] !== 32'd7 || stall_cnt[0] !== 32'd1) begin
      errors++; $display("FAIL perf_stall_cnt got %0d/%0d expected 7/1", stall_cnt[1], stall_cnt[0]);
    end
    checks++;
    if (grant_cnt[0] !== 32'd1 || grant_cnt[1] !== 32'd1) begin
      errors++; $display("FAIL perf_grant_after_clear got %0d/%0d expected 1/1", grant_cnt[0], grant_cnt[1]);
    end
  endtask
`endif

  initial begin
    bus.iREN = '0; bus.iaddr = '0; bus.dREN = '0; bus.dWEN = '0;
    bus.daddr = '0; bus.dstore = '0; bus.ramload = '0; bus.ramstate = FREE;
    test_reset();
    test_ifetch();
    test_d_over_i();
    test_rotation();
    test_withdraw();
    test_reset_mid_grant();
`ifdef MEMARB_PERF_EN
    test_perf();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish within 200000 time units");
    $fatal(1);
  end

endmodule
